// File: rtl/if_stage_pf_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect strobe
// and the decode-side handoff. master = fetch stage, slave = its environment.
interface if_stage_pf_if;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        ds_allow_in;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;

  modport master (
    output inst_sram_req, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  br_taken, br_target, ds_allow_in,
    output fs_to_ds_valid, fs_pc, fs_inst, fs_adef
  );

  modport slave (
    input  inst_sram_req, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output br_taken, br_target, ds_allow_in,
    input  fs_to_ds_valid, fs_pc, fs_inst, fs_adef
  );
endinterface

// File: rtl/if_stage_pf.sv
// Instruction-fetch stage with a prefetch queue, split req/resp memory port,
// redirect flush of in-flight responses and ADEF reporting for misaligned PCs.
module if_stage_pf #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic          clk,
  input logic          reset,
  if_stage_pf_if.master bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned QW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [OW-1:0] cancel_cnt_q, cancel_cnt_d;
  logic [QW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          stall_q, stall_d;
  logic [31:0]   q_pc_q   [FIFO_DEPTH];
  logic [31:0]   q_pc_d   [FIFO_DEPTH];
  logic [31:0]   q_inst_q [FIFO_DEPTH];
  logic [31:0]   q_inst_d [FIFO_DEPTH];
  logic          q_adef_q [FIFO_DEPTH];
  logic          q_adef_d [FIFO_DEPTH];

  logic          req;
  logic          fire;
  logic          dok;
  logic          drop;
  logic          push_resp;
  logic          adef_push;
  logic          push;
  logic          pop;
  logic          misaligned;
  logic [SW-1:0] live_sum;

  // cancel_cnt never exceeds out_cnt, so the subtraction cannot wrap.
  assign live_sum   = SW'(out_cnt_q) - SW'(cancel_cnt_q) + SW'(count_q);
  assign misaligned = (fetch_pc_q[1:0] != 2'b00);

  assign req = !reset && !stall_q && !misaligned &&
               (out_cnt_q < OW'(MAX_OUTSTANDING)) &&
               (live_sum < SW'(FIFO_DEPTH));

  assign fire      = req && bus.inst_sram_addr_ok;
  assign dok       = bus.inst_sram_data_ok && (out_cnt_q != '0);
  assign drop      = dok && (cancel_cnt_q != '0);
  assign push_resp = dok && !drop;
  assign adef_push = !stall_q && misaligned && (out_cnt_q == cancel_cnt_q) &&
                     (count_q < QW'(FIFO_DEPTH));
  assign push      = push_resp || adef_push;
  assign pop       = (count_q != '0) && bus.ds_allow_in;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_pc_d    = resp_pc_q;
    out_cnt_d    = out_cnt_q + OW'(fire) - OW'(dok);
    cancel_cnt_d = cancel_cnt_q - OW'(drop);
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    stall_d      = stall_q;
    q_pc_d       = q_pc_q;
    q_inst_d     = q_inst_q;
    q_adef_d     = q_adef_q;

    if (bus.br_taken) begin
      // Everything in flight after this edge belongs to the old path.
      fetch_pc_d   = bus.br_target;
      resp_pc_d    = bus.br_target;
      cancel_cnt_d = out_cnt_d;
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      stall_d      = 1'b0;
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push_resp) resp_pc_d = resp_pc_q + 32'd4;
      if (adef_push) stall_d = 1'b1;
      if (push) begin
        q_pc_d[wr_ptr_q]   = push_resp ? resp_pc_q : fetch_pc_q;
        q_inst_d[wr_ptr_q] = push_resp ? bus.inst_sram_rdata : '0;
        q_adef_d[wr_ptr_q] = adef_push;
        wr_ptr_d           = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + QW'(push) - QW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      resp_pc_q    <= RESET_PC;
      out_cnt_q    <= '0;
      cancel_cnt_q <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      stall_q      <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        q_pc_q[i]   <= '0;
        q_inst_q[i] <= '0;
        q_adef_q[i] <= 1'b0;
      end
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_pc_q    <= resp_pc_d;
      out_cnt_q    <= out_cnt_d;
      cancel_cnt_q <= cancel_cnt_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      stall_q      <= stall_d;
      q_pc_q       <= q_pc_d;
      q_inst_q     <= q_inst_d;
      q_adef_q     <= q_adef_d;
    end
  end

  assign bus.inst_sram_req  = req;
  assign bus.inst_sram_addr = fetch_pc_q;
  assign bus.fs_to_ds_valid = (count_q != '0);
  assign bus.fs_pc          = q_pc_q[rd_ptr_q];
  assign bus.fs_inst        = q_inst_q[rd_ptr_q];
  assign bus.fs_adef        = q_adef_q[rd_ptr_q];

endmodule

// File: tb/tb_if_stage_pf.sv
// Directed bench for if_stage_pf: streaming, back-pressure, redirects with
// in-flight cancellation, ADEF stall/resume and mid-run reset.
module tb_if_stage_pf;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk;
  logic        reset;
  int          n_chk;
  int          n_pass;
  int          mem_lat;
  int          cyc;
  logic [31:0] exp_pc;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  if_stage_pf_if bus();

  if_stage_pf #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // In-order memory: a request accepted in cycle c answers in cycle c+mem_lat.
  initial begin
    bus.inst_sram_addr_ok = 1'b0;
    bus.inst_sram_data_ok = 1'b0;
    bus.inst_sram_rdata   = '0;
    cyc = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (reset) begin
        mq_addr.delete();
        mq_due.delete();
        bus.inst_sram_data_ok = 1'b0;
        bus.inst_sram_addr_ok = 1'b0;
      end else begin
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
          bus.inst_sram_data_ok = 1'b1;
          bus.inst_sram_rdata   = mem_word(mq_addr[0]);
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end else begin
          bus.inst_sram_data_ok = 1'b0;
        end
        bus.inst_sram_addr_ok = 1'b1;
        if (bus.inst_sram_req) begin
          mq_addr.push_back(bus.inst_sram_addr);
          mq_due.push_back(cyc + mem_lat);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_req",   32'(bus.inst_sram_req), 32'd0);
    check("rst_addr",  bus.inst_sram_addr, RST_PC);
    check("rst_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    check("rst_pc",    bus.fs_pc, 32'd0);
    check("rst_inst",  bus.fs_inst, 32'd0);
    check("rst_adef",  32'(bus.fs_adef), 32'd0);
  endtask

  // One cycle: the head must be present; allow decides whether it pops.
  task automatic step(input logic allow);
    @(negedge clk);
    check("step_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    check("step_pc",    bus.fs_pc, exp_pc);
    check("step_inst",  bus.fs_inst, mem_word(exp_pc));
    bus.ds_allow_in = allow;
    if (allow) exp_pc += 32'd4;
  endtask

  task automatic next_head(input logic adef);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!bus.fs_to_ds_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("head_valid", 32'(bus.fs_to_ds_valid), 32'd1);
    check("head_pc",    bus.fs_pc, exp_pc);
    check("head_adef",  32'(bus.fs_adef), 32'(adef));
    check("head_inst",  bus.fs_inst, adef ? 32'd0 : mem_word(exp_pc));
    bus.ds_allow_in = 1'b1;
    exp_pc += 32'd4;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    mem_lat = 1;
    reset = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    bus.ds_allow_in = 1'b1;

    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("first_req",  32'(bus.inst_sram_req), 32'd1);
    check("first_addr", bus.inst_sram_addr, RST_PC);
    @(negedge clk);
    check("no_bypass", 32'(bus.fs_to_ds_valid), 32'd0);

    // Zero-wait streaming: one instruction per cycle.
    exp_pc = RST_PC;
    repeat (8) step(1'b1);

    // Back-pressure: queue fills to 4, requests stop, order preserved.
    repeat (10) step(1'b0);
    check("full_req",   32'(bus.inst_sram_req), 32'd0);
    check("full_count", 32'(dut.count_q), 32'd4);
    repeat (10) step(1'b1);

    // Redirect coinciding with an accepted request and a response.
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c000080;
    #2;
    check("coincide", 32'({bus.inst_sram_req, bus.inst_sram_addr_ok, bus.inst_sram_data_ok}), 32'd7);
    @(negedge clk);
    bus.br_taken = 1'b0;
    check("redir_valid1", 32'(bus.fs_to_ds_valid), 32'd0);
    check("redir_cancel", 32'(dut.cancel_cnt_q), 32'd1);
    #2;
    check("redir_req",  32'(bus.inst_sram_req), 32'd1);
    check("redir_addr", bus.inst_sram_addr, 32'h1c000080);
    @(negedge clk);
    check("redir_valid2", 32'(bus.fs_to_ds_valid), 32'd0);
    exp_pc = 32'h1c000080;
    repeat (4) step(1'b1);

    // Slow memory, redirect with two requests in flight.
    mem_lat = 3;
    repeat (3) next_head(1'b0);
    for (int i = 0; i < 20 && dut.out_cnt_q != 2; i++) @(negedge clk);
    check("inflight2", 32'(dut.out_cnt_q), 32'd2);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c000100;
    @(negedge clk);
    bus.br_taken = 1'b0;
    check("slow_valid", 32'(bus.fs_to_ds_valid), 32'd0);
    exp_pc = 32'h1c000100;
    repeat (3) next_head(1'b0);

    // Misaligned redirect: single ADEF entry, then silence until redirect.
    mem_lat = 1;
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c000102;
    @(negedge clk);
    bus.br_taken = 1'b0;
    #1;
    check("adef_noreq", 32'(bus.inst_sram_req), 32'd0);
    exp_pc = 32'h1c000102;
    next_head(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("adef_quiet_valid", 32'(bus.fs_to_ds_valid), 32'd0);
      check("adef_quiet_req",   32'(bus.inst_sram_req), 32'd0);
    end
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1c000200;
    @(negedge clk);
    bus.br_taken = 1'b0;
    exp_pc = 32'h1c000200;
    repeat (3) next_head(1'b0);

    // Reset while the queue holds three entries.
    @(negedge clk);
    bus.ds_allow_in = 1'b0;
    for (int i = 0; i < 20 && dut.count_q != 3; i++) @(negedge clk);
    check("fill3", 32'(dut.count_q), 32'd3);
    reset = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    bus.ds_allow_in = 1'b1;
    exp_pc = RST_PC;
    repeat (4) next_head(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
